// File: rtl/icetap_capture_ctrl.sv
// icetap_capture_ctrl: sequences one icetap recording into the circular record RAM
// and publishes the start/trigger/stop addresses of the last recording for JTAG readout.
module icetap_capture_ctrl #(
    parameter int NR_SIGNALS   = 16,
    parameter int RECORD_DEPTH = 512,
    parameter int ADDR_W       = $clog2(RECORD_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_start,
    input  logic                  cmd_abort,
    input  logic [ADDR_W-1:0]     pretrig_depth,
    input  logic [NR_SIGNALS-1:0] signals_in,
    input  logic                  store,
    input  logic                  trigger,
    output logic                  ram_wr_ena,
    output logic [ADDR_W-1:0]     ram_wr_addr,
    output logic [NR_SIGNALS-1:0] ram_wr_data,
    output logic [1:0]            status_state,
    output logic                  status_idle,
    output logic                  status_triggered,
    output logic [ADDR_W-1:0]     status_start_addr,
    output logic [ADDR_W-1:0]     status_trigger_addr,
    output logic [ADDR_W-1:0]     status_stop_addr,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRE_TRIG  = 2'd1,
        ST_WAIT_TRIG = 2'd2,
        ST_POST_TRIG = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RECORD_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t                r_state, w_state;
    logic [ADDR_W-1:0]     r_wr_ptr, w_wr_ptr;
    logic [ADDR_W-1:0]     r_cnt, w_cnt;
    logic [ADDR_W-1:0]     r_post, w_post;
    logic [ADDR_W-1:0]     r_pretrig, w_pretrig;
    logic [ADDR_W-1:0]     r_trig_addr, w_trig_addr;
    logic [ADDR_W-1:0]     r_start_addr, w_start_addr;
    logic [ADDR_W-1:0]     r_trigger_addr, w_trigger_addr;
    logic [ADDR_W-1:0]     r_stop_addr, w_stop_addr;
    logic [ADDR_W-1:0]     r_wr_addr, w_wr_addr;
    logic                  r_wrapped, w_wrapped;
    logic                  r_triggered, w_triggered;
    logic                  r_done, w_done;
    logic                  r_wr_ena, w_wr_ena;
    logic                  r_idle;
    logic [NR_SIGNALS-1:0] r_wr_data;
    logic                  w_write;
    logic                  w_complete;

    // r_trig_addr is the private trigger position; the published copy only moves at the end
    always_comb begin
        w_state        = r_state;
        w_wr_ptr       = r_wr_ptr;
        w_cnt          = r_cnt;
        w_post         = r_post;
        w_pretrig      = r_pretrig;
        w_trig_addr    = r_trig_addr;
        w_start_addr   = r_start_addr;
        w_trigger_addr = r_trigger_addr;
        w_stop_addr    = r_stop_addr;
        w_wr_addr      = r_wr_addr;
        w_wrapped      = r_wrapped;
        w_triggered    = r_triggered;
        w_done         = 1'b0;
        w_wr_ena       = 1'b0;
        w_write        = 1'b0;
        w_complete     = 1'b0;

        if (r_state != ST_IDLE && cmd_abort) begin
            w_state = ST_IDLE;
            w_done  = 1'b1;
            if (!r_wrapped && r_wr_ptr == '0) begin
                w_stop_addr    = '0;
                w_start_addr   = '0;
                w_trigger_addr = '0;
            end else begin
                w_stop_addr    = r_wr_ptr - ONE;
                w_start_addr   = r_wrapped ? r_wr_ptr : '0;
                w_trigger_addr = r_triggered ? r_trig_addr : (r_wr_ptr - ONE);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        w_wr_ptr    = '0;
                        w_cnt       = '0;
                        w_wrapped   = 1'b0;
                        w_triggered = 1'b0;
                        w_pretrig   = pretrig_depth;
                        w_state     = (pretrig_depth == '0) ? ST_WAIT_TRIG : ST_PRE_TRIG;
                    end
                end
                ST_PRE_TRIG: begin
                    if (store) begin
                        w_write = 1'b1;
                        w_cnt   = r_cnt + ONE;
                        if (r_cnt + ONE == r_pretrig) begin
                            w_state = ST_WAIT_TRIG;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trigger) begin
                        w_write     = 1'b1;
                        w_trig_addr = r_wr_ptr;
                        w_triggered = 1'b1;
                        w_post      = LAST_ADDR - r_pretrig;
                        if (LAST_ADDR - r_pretrig == '0) begin
                            w_complete = 1'b1;
                        end else begin
                            w_state = ST_POST_TRIG;
                        end
                    end else if (store) begin
                        w_write = 1'b1;
                    end
                end
                ST_POST_TRIG: begin
                    if (store) begin
                        w_write = 1'b1;
                        w_post  = r_post - ONE;
                        if (r_post == ONE) begin
                            w_complete = 1'b1;
                        end
                    end
                end
            endcase
        end

        if (w_write) begin
            w_wr_ena  = 1'b1;
            w_wr_addr = r_wr_ptr;
            w_wr_ptr  = r_wr_ptr + ONE;
            if (r_wr_ptr == LAST_ADDR) begin
                w_wrapped = 1'b1;
            end
        end

        // The completing write is the newest sample, so the oldest one sits right after it
        if (w_complete) begin
            w_state        = ST_IDLE;
            w_done         = 1'b1;
            w_stop_addr    = r_wr_ptr;
            w_start_addr   = r_wr_ptr + ONE;
            w_trigger_addr = w_trig_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_wr_ptr       <= '0;
            r_cnt          <= '0;
            r_post         <= '0;
            r_pretrig      <= '0;
            r_trig_addr    <= '0;
            r_start_addr   <= '0;
            r_trigger_addr <= '0;
            r_stop_addr    <= '0;
            r_wr_addr      <= '0;
            r_wrapped      <= 1'b0;
            r_triggered    <= 1'b0;
            r_done         <= 1'b0;
            r_wr_ena       <= 1'b0;
            r_idle         <= 1'b1;
            r_wr_data      <= '0;
        end else begin
            r_state        <= w_state;
            r_wr_ptr       <= w_wr_ptr;
            r_cnt          <= w_cnt;
            r_post         <= w_post;
            r_pretrig      <= w_pretrig;
            r_trig_addr    <= w_trig_addr;
            r_start_addr   <= w_start_addr;
            r_trigger_addr <= w_trigger_addr;
            r_stop_addr    <= w_stop_addr;
            r_wr_addr      <= w_wr_addr;
            r_wrapped      <= w_wrapped;
            r_triggered    <= w_triggered;
            r_done         <= w_done;
            r_wr_ena       <= w_wr_ena;
            r_idle         <= (w_state == ST_IDLE);
            r_wr_data      <= signals_in;
        end
    end

    assign ram_wr_ena          = r_wr_ena;
    assign ram_wr_addr         = r_wr_addr;
    assign ram_wr_data         = r_wr_data;
    assign status_state        = r_state;
    assign status_idle         = r_idle;
    assign status_triggered    = r_triggered;
    assign status_start_addr   = r_start_addr;
    assign status_trigger_addr = r_trigger_addr;
    assign status_stop_addr    = r_stop_addr;
    assign done                = r_done;

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Self-checking bench for icetap_capture_ctrl: a per-cycle scoreboard of expected RAM
// writes, state and done pulses, plus fixed status expectations per recording scenario.
module tb_icetap_capture_ctrl;

    localparam int NS    = 16;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_start;
    logic          cmd_abort;
    logic [AW-1:0] pretrig_depth;
    logic [NS-1:0] signals_in;
    logic          store;
    logic          trigger;
    logic          ram_wr_ena;
    logic [AW-1:0] ram_wr_addr;
    logic [NS-1:0] ram_wr_data;
    logic [1:0]    status_state;
    logic          status_idle;
    logic          status_triggered;
    logic [AW-1:0] status_start_addr;
    logic [AW-1:0] status_trigger_addr;
    logic [AW-1:0] status_stop_addr;
    logic          done;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [NS-1:0] data;
        logic [1:0]    state;
        bit            done;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  n_wr   = 0;

    // Reference model: samples written so far decide the address, phases by sample counts
    int m_state = 0;
    int m_cnt   = 0;
    int m_post  = 0;
    int m_pre   = 0;
    int m_nw    = 0;

    icetap_capture_ctrl #(
        .NR_SIGNALS  (NS),
        .RECORD_DEPTH(DEPTH)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_start          (cmd_start),
        .cmd_abort          (cmd_abort),
        .pretrig_depth      (pretrig_depth),
        .signals_in         (signals_in),
        .store              (store),
        .trigger            (trigger),
        .ram_wr_ena         (ram_wr_ena),
        .ram_wr_addr        (ram_wr_addr),
        .ram_wr_data        (ram_wr_data),
        .status_state       (status_state),
        .status_idle        (status_idle),
        .status_triggered   (status_triggered),
        .status_start_addr  (status_start_addr),
        .status_trigger_addr(status_trigger_addr),
        .status_stop_addr   (status_stop_addr),
        .done               (done)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: at the falling edge, first score the output produced by the
    // previous cycle's inputs, then apply new inputs and push what they should produce.
    task automatic drive_cycle(input bit st, input bit ab, input bit sto, input bit trg);
        sb_t e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (ram_wr_ena !== e.wr) begin
                errors++;
                $display("[TB] FAIL wr_ena @%0t: got %b want %b", $time, ram_wr_ena, e.wr);
            end
            if (e.wr) begin
                checks++;
                if (ram_wr_addr !== e.addr || ram_wr_data !== e.data) begin
                    errors++;
                    $display("[TB] FAIL wr_addr/data @%0t: got %0d/%h want %0d/%h",
                             $time, ram_wr_addr, ram_wr_data, e.addr, e.data);
                end
            end
            checks++;
            if (status_state !== e.state || status_idle !== (e.state == 2'd0)) begin
                errors++;
                $display("[TB] FAIL state/idle @%0t: got %0d/%b want %0d/%b",
                         $time, status_state, status_idle, e.state, (e.state == 2'd0));
            end
            checks++;
            if (done !== e.done) begin
                errors++;
                $display("[TB] FAIL done @%0t: got %b want %b", $time, done, e.done);
            end
        end else begin
            checks++;
            if (ram_wr_ena !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_wr_ena @%0t: got %b want 0", $time, ram_wr_ena);
            end
        end
        if (ram_wr_ena === 1'b1) n_wr++;

        cmd_start  = st;
        cmd_abort  = ab;
        store      = sto;
        trigger    = trg;
        signals_in = NS'($urandom);

        e.wr   = 1'b0;
        e.addr = '0;
        e.data = signals_in;
        e.done = 1'b0;
        if (m_state != 0 && ab) begin
            m_state = 0;
            e.done  = 1'b1;
        end else begin
            case (m_state)
                0: if (st) begin
                    m_pre   = int'(pretrig_depth);
                    m_cnt   = 0;
                    m_nw    = 0;
                    m_state = (m_pre == 0) ? 2 : 1;
                end
                1: if (sto) begin
                    e.wr = 1'b1;
                    m_cnt++;
                    if (m_cnt == m_pre) m_state = 2;
                end
                2: if (trg) begin
                    e.wr   = 1'b1;
                    m_post = DEPTH - 1 - m_pre;
                    if (m_post == 0) begin
                        m_state = 0;
                        e.done  = 1'b1;
                    end else begin
                        m_state = 3;
                    end
                end else if (sto) begin
                    e.wr = 1'b1;
                end
                3: if (sto) begin
                    e.wr = 1'b1;
                    m_post--;
                    if (m_post == 0) begin
                        m_state = 0;
                        e.done  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (e.wr) begin
            e.addr = AW'(m_nw % DEPTH);
            m_nw++;
        end
        e.state = 2'(m_state);
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        cmd_start     = 1'b0;
        cmd_abort     = 1'b0;
        store         = 1'b0;
        trigger       = 1'b0;
        signals_in    = '0;
        pretrig_depth = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (status_state !== 2'd0 || status_idle !== 1'b1 || done !== 1'b0 || ram_wr_ena !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got state=%0d idle=%b done=%b ena=%b want 0/1/0/0",
                     status_state, status_idle, done, ram_wr_ena);
        end
        checks++;
        if (status_start_addr !== '0 || status_trigger_addr !== '0 || status_stop_addr !== '0 ||
            status_triggered !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: got start=%0d trig=%0d stop=%0d triggered=%b want 0/0/0/0",
                     status_start_addr, status_trigger_addr, status_stop_addr, status_triggered);
        end
        reset = 1'b0;
    endtask

    task automatic test_pretrig_zero();
        int wr0;
        pretrig_depth = 9'd0;
        wr0 = n_wr;
        drive_cycle(1, 0, 0, 0);
        repeat (5) drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 0, 1, 1);
        repeat (511) drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 0, 1, 0);
        // 5 samples before the trigger plus the 512 from the trigger onward
        checks++;
        if (n_wr - wr0 != 517) begin
            errors++;
            $display("[TB] FAIL pretrig0_writes: got %0d want 517", n_wr - wr0);
        end
        checks++;
        if (status_trigger_addr !== 9'd5 || status_stop_addr !== 9'd4 || status_start_addr !== 9'd5 ||
            status_triggered !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pretrig0_status: got trig=%0d stop=%0d start=%0d triggered=%b want 5/4/5/1",
                     status_trigger_addr, status_stop_addr, status_start_addr, status_triggered);
        end
    endtask

    task automatic test_pretrig_half();
        int wr0;
        pretrig_depth = 9'd256;
        drive_cycle(1, 0, 0, 0);
        wr0 = n_wr;
        repeat (512) drive_cycle(0, 0, 1, 1);
        drive_cycle(0, 0, 0, 0);
        checks++;
        if (n_wr - wr0 != 512) begin
            errors++;
            $display("[TB] FAIL half_writes: got %0d want 512", n_wr - wr0);
        end
        checks++;
        if (status_trigger_addr !== 9'd256 || status_start_addr !== 9'd0 || status_stop_addr !== 9'd511) begin
            errors++;
            $display("[TB] FAIL half_status: got trig=%0d start=%0d stop=%0d want 256/0/511",
                     status_trigger_addr, status_start_addr, status_stop_addr);
        end
    endtask

    task automatic test_store_toggle();
        int i;
        pretrig_depth = 9'd4;
        drive_cycle(1, 0, 0, 0);
        i = 0;
        while (m_state != 0 && i < 2000) begin
            drive_cycle(0, 0, (i % 2) == 0, i == 19);
            i++;
        end
        drive_cycle(0, 0, 0, 0);
        // 4 pre + 6 waiting + trigger at 10 + 507 post: newest at 517 mod 512
        checks++;
        if (status_trigger_addr !== 9'd10 || status_start_addr !== 9'd6 || status_stop_addr !== 9'd5) begin
            errors++;
            $display("[TB] FAIL toggle_status: got trig=%0d start=%0d stop=%0d want 10/6/5",
                     status_trigger_addr, status_start_addr, status_stop_addr);
        end
        checks++;
        if (AW'(status_trigger_addr - status_start_addr) !== 9'd4) begin
            errors++;
            $display("[TB] FAIL toggle_invariant: got %0d want 4",
                     AW'(status_trigger_addr - status_start_addr));
        end
    endtask

    task automatic test_abort();
        int wr0;
        pretrig_depth = 9'd8;
        drive_cycle(1, 0, 0, 0);
        wr0 = n_wr;
        repeat (300) drive_cycle(0, 0, 1, 0);
        checks++;
        if (status_stop_addr !== 9'd5 || status_start_addr !== 9'd6 || status_trigger_addr !== 9'd10 ||
            status_triggered !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_stable: got stop=%0d start=%0d trig=%0d triggered=%b want 5/6/10/0",
                     status_stop_addr, status_start_addr, status_trigger_addr, status_triggered);
        end
        repeat (300) drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 1, 1, 1);
        drive_cycle(0, 0, 0, 0);
        checks++;
        if (n_wr - wr0 != 600) begin
            errors++;
            $display("[TB] FAIL abort_writes: got %0d want 600", n_wr - wr0);
        end
        checks++;
        if (status_stop_addr !== 9'd87 || status_start_addr !== 9'd88 || status_trigger_addr !== 9'd87 ||
            status_triggered !== 1'b0 || status_idle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_status: got stop=%0d start=%0d trig=%0d triggered=%b idle=%b want 87/88/87/0/1",
                     status_stop_addr, status_start_addr, status_trigger_addr, status_triggered, status_idle);
        end
    endtask

    task automatic test_ignored_cmds();
        drive_cycle(1, 1, 1, 1);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        checks++;
        if (status_stop_addr !== 9'd87 || status_start_addr !== 9'd88) begin
            errors++;
            $display("[TB] FAIL start_abort_idle: got stop=%0d start=%0d want 87/88",
                     status_stop_addr, status_start_addr);
        end
        pretrig_depth = 9'd0;
        drive_cycle(1, 0, 0, 0);
        repeat (2) drive_cycle(0, 0, 0, 0);
        pretrig_depth = 9'd7;
        drive_cycle(1, 0, 0, 0);
        repeat (2) drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 1, 0, 0);
        drive_cycle(0, 0, 0, 0);
        checks++;
        if (status_stop_addr !== '0 || status_start_addr !== '0 || status_trigger_addr !== '0 ||
            status_triggered !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_abort: got stop=%0d start=%0d trig=%0d triggered=%b want 0/0/0/0",
                     status_stop_addr, status_start_addr, status_trigger_addr, status_triggered);
        end
    endtask

    task automatic test_back_to_back();
        pretrig_depth = 9'd511;
        drive_cycle(1, 0, 0, 0);
        repeat (511) drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 0, 0, 1);
        pretrig_depth = 9'd0;
        drive_cycle(1, 0, 0, 0);
        checks++;
        if (status_trigger_addr !== 9'd511 || status_stop_addr !== 9'd511 || status_start_addr !== 9'd0) begin
            errors++;
            $display("[TB] FAIL max_pretrig_status: got trig=%0d stop=%0d start=%0d want 511/511/0",
                     status_trigger_addr, status_stop_addr, status_start_addr);
        end
        repeat (3) drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 1, 0, 0);
        drive_cycle(0, 0, 0, 0);
        checks++;
        if (status_stop_addr !== 9'd2 || status_start_addr !== 9'd0 || status_trigger_addr !== 9'd2 ||
            status_triggered !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_abort: got stop=%0d start=%0d trig=%0d triggered=%b want 2/0/2/0",
                     status_stop_addr, status_start_addr, status_trigger_addr, status_triggered);
        end
    endtask

    task automatic test_async_reset();
        pretrig_depth = 9'd2;
        drive_cycle(1, 0, 0, 0);
        repeat (2) drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 0, 0, 1);
        repeat (3) drive_cycle(0, 0, 1, 0);
        @(posedge clk);
        #1;
        checks++;
        if (ram_wr_ena !== 1'b1 || status_state !== 2'd3) begin
            errors++;
            $display("[TB] FAIL pre_reset: got ena=%b state=%0d want 1/3", ram_wr_ena, status_state);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (ram_wr_ena !== 1'b0 || status_state !== 2'd0 || status_idle !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_ctrl: got ena=%b state=%0d idle=%b done=%b want 0/0/1/0",
                     ram_wr_ena, status_state, status_idle, done);
        end
        checks++;
        if (status_start_addr !== '0 || status_trigger_addr !== '0 || status_stop_addr !== '0 ||
            status_triggered !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_status: got start=%0d trig=%0d stop=%0d triggered=%b want 0/0/0/0",
                     status_start_addr, status_trigger_addr, status_stop_addr, status_triggered);
        end
        sb_q.delete();
        m_state   = 0;
        cmd_start = 1'b0;
        store     = 1'b0;
        trigger   = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        pretrig_depth = 9'd0;
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 0, 1, 1);
        repeat (511) drive_cycle(0, 0, 1, 0);
        drive_cycle(0, 0, 0, 0);
        checks++;
        if (status_trigger_addr !== 9'd0 || status_start_addr !== 9'd0 || status_stop_addr !== 9'd511 ||
            status_triggered !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_reset: got trig=%0d start=%0d stop=%0d triggered=%b want 0/0/511/1",
                     status_trigger_addr, status_start_addr, status_stop_addr, status_triggered);
        end
    endtask

    initial begin
        test_reset();
        test_pretrig_zero();
        test_pretrig_half();
        test_store_toggle();
        test_abort();
        test_ignored_cmds();
        test_back_to_back();
        test_async_reset();
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
